// File: rtl/mandel_coord_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : mandel_coord_gen                                              |
// | Description : Raster-order pixel sweep emitting one signed 4.23 complex     |
// |               coordinate per pixel on a valid/ready source interface.       |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module mandel_coord_gen #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int XW       = $clog2(H_PIXELS),
  parameter int YW       = $clog2(V_PIXELS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [26:0]   cfg_r_left,
  input  logic [26:0]   cfg_i_top,
  input  logic [26:0]   cfg_dx,
  input  logic [26:0]   cfg_dy,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [26:0]   out_c_r,
  output logic [26:0]   out_c_i,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [1:0]    c_IDLE   = 2'd0;
  localparam logic [1:0]    c_RUN    = 2'd1;
  localparam logic [1:0]    c_DONE   = 2'd2;
  localparam logic [XW-1:0] c_X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] c_Y_LAST = YW'(V_PIXELS - 1);
  localparam logic [XW-1:0] c_X_ONE  = XW'(1);
  localparam logic [YW-1:0] c_Y_ONE  = YW'(1);

  logic [1:0]    r_state;
  logic [26:0]   r_r_left;
  logic [26:0]   r_dx;
  logic [26:0]   r_dy;
  logic [26:0]   r_c_r;
  logic [26:0]   r_c_i;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_val;
  logic          r_busy;
  logic          r_done;

  logic w_xfer;
  logic w_row_end;
  logic w_last_row;

  assign w_xfer     = r_val & out_rdy;
  assign w_row_end  = (r_x == c_X_LAST);
  assign w_last_row = (r_y == c_Y_LAST);

  // The top-row imaginary value is only needed once, so it is loaded straight
  // into the c_i accumulator instead of being kept in its own register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_IDLE;
      r_r_left <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_c_r    <= '0;
      r_c_i    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_val    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start && !abort) begin
            r_r_left <= cfg_r_left;
            r_dx     <= cfg_dx;
            r_dy     <= cfg_dy;
            r_c_r    <= cfg_r_left;
            r_c_i    <= cfg_i_top;
            r_x      <= '0;
            r_y      <= '0;
            r_val    <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= c_RUN;
          end
        end
        c_RUN: begin
          if (abort) begin
            r_val   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= c_IDLE;
          end else if (w_xfer) begin
            if (!w_row_end) begin
              r_x   <= r_x + c_X_ONE;
              r_c_r <= r_c_r + r_dx;
            end else if (!w_last_row) begin
              // Reload c_r at each row start so no error accumulates down the frame.
              r_x   <= '0;
              r_y   <= r_y + c_Y_ONE;
              r_c_r <= r_r_left;
              r_c_i <= r_c_i - r_dy;
            end else begin
              r_val   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= c_DONE;
            end
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_val   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign out_val    = r_val;
  assign out_c_r    = r_c_r;
  assign out_c_i    = r_c_i;
  assign out_x      = r_x;
  assign out_y      = r_y;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mandel_coord_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_mandel_coord_gen                                           |
// | Description : Directed self-checking bench for mandel_coord_gen (4x3 grid). |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_mandel_coord_gen;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int XW = 2;
  localparam int YW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [26:0]   cfg_r_left;
  logic [26:0]   cfg_i_top;
  logic [26:0]   cfg_dx;
  logic [26:0]   cfg_dy;
  logic          out_val;
  logic          out_rdy;
  logic [26:0]   out_c_r;
  logic [26:0]   out_c_i;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          busy;
  logic          frame_done;

  int n_vec = 0;
  int n_err = 0;

  // Hand-computed coordinates: c_r = -2.0 + 0.5*x, c_i = 1.0 - 0.5*y in 4.23.
  logic [26:0] exp_cr [H] = '{27'h7000000, 27'h7400000, 27'h7800000, 27'h7C00000};
  logic [26:0] exp_ci [V] = '{27'h0800000, 27'h0400000, 27'h0000000};

  mandel_coord_gen #(
    .H_PIXELS (H),
    .V_PIXELS (V)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .cfg_r_left (cfg_r_left),
    .cfg_i_top  (cfg_i_top),
    .cfg_dx     (cfg_dx),
    .cfg_dy     (cfg_dy),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_c_r    (out_c_r),
    .out_c_i    (out_c_i),
    .out_x      (out_x),
    .out_y      (out_y),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_std_cfg();
    cfg_r_left = 27'h7000000;
    cfg_i_top  = 27'h0800000;
    cfg_dx     = 27'h0400000;
    cfg_dy     = 27'h0400000;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_val"},  out_val, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_cr"},   out_c_r, 0);
    check({tag, "_ci"},   out_c_i, 0);
    check({tag, "_x"},    out_x, 0);
    check({tag, "_y"},    out_y, 0);
  endtask

  // mode 0: rdy always 1, mode 1: random rdy, mode 2: rdy one cycle in four
  task automatic run_frame(input int mode);
    int          idx     = 0;
    int          cyc     = 0;
    bit          stalled = 0;
    logic [26:0] h_cr, h_ci;
    logic [XW-1:0] h_x;
    logic [YW-1:0] h_y;
    h_cr = '0; h_ci = '0; h_x = '0; h_y = '0;
    @(negedge clk);
    set_std_cfg();
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cfg_r_left = 27'h1234567;
    cfg_i_top  = 27'h2345678;
    cfg_dx     = 27'h0000111;
    cfg_dy     = 27'h0000222;
    while (idx < H * V && cyc < 200) begin
      case (mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'($urandom_range(0, 1));
        default: out_rdy = ((cyc % 4) == 3);
      endcase
      if (stalled) begin
        check("hold_cr", out_c_r, h_cr);
        check("hold_ci", out_c_i, h_ci);
        check("hold_x",  out_x, h_x);
        check("hold_y",  out_y, h_y);
      end
      if (mode != 1 && out_rdy) check("val_at_rdy", out_val, 1);
      check("busy_run", busy, 1);
      if (out_val && out_rdy) begin
        check("c_r", out_c_r, exp_cr[idx % H]);
        check("c_i", out_c_i, exp_ci[idx / H]);
        check("x",   out_x, idx % H);
        check("y",   out_y, idx / H);
        idx++;
        stalled = 0;
      end else begin
        stalled = out_val;
        h_cr = out_c_r; h_ci = out_c_i; h_x = out_x; h_y = out_y;
      end
      cyc++;
      @(negedge clk);
    end
    check("xfer_count", idx, H * V);
    out_rdy = 1'b0;
    start   = 1'b1;
    check("done_pulse", frame_done, 1);
    check("done_val",   out_val, 0);
    check("done_busy",  busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("done_clear",   frame_done, 0);
    check("no_restart",   out_val, 0);
    check("idle_busy",    busy, 0);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    out_rdy = 1'b0;
    set_std_cfg();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_val", out_val, 0);

    run_frame(0);
    run_frame(1);
    run_frame(2);

    // Abort after five transfers, coinciding with a sixth handshake.
    @(negedge clk);
    set_std_cfg();
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    out_rdy = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_abort_x",  out_x, 1);
    check("pre_abort_y",  out_y, 1);
    check("pre_abort_cr", out_c_r, 27'h7400000);
    check("pre_abort_ci", out_c_i, 27'h0400000);
    abort = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    out_rdy = 1'b0;
    check("abort_val",  out_val, 0);
    check("abort_busy", busy, 0);
    check("abort_done", frame_done, 0);
    @(negedge clk);
    check("abort_done2", frame_done, 0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_over_start", out_val, 0);
    run_frame(0);

    // Asynchronous reset mid-row while start is held high.
    @(negedge clk);
    set_std_cfg();
    start = 1'b1;
    @(negedge clk);
    out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("start_ignored_x", out_x, 3);
    check("start_ignored_y", out_y, 0);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_val",  out_val, 0);
    check("post_rst_busy", busy, 0);

    // Two's-complement wrap on c_r step and on c_i row step.
    cfg_r_left = 27'h3FFFFFF;
    cfg_i_top  = 27'h4000000;
    cfg_dx     = 27'h0000001;
    cfg_dy     = 27'h0000001;
    start      = 1'b1;
    out_rdy    = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    out_rdy = 1'b1;
    check("wrap_cr0", out_c_r, 27'h3FFFFFF);
    @(negedge clk);
    check("wrap_cr1", out_c_r, 27'h4000000);
    @(negedge clk);
    check("wrap_cr2", out_c_r, 27'h4000001);
    repeat (2) @(negedge clk);
    check("wrap_row_x",  out_x, 0);
    check("wrap_row_cr", out_c_r, 27'h3FFFFFF);
    check("wrap_row_ci", out_c_i, 27'h3FFFFFF);
    abort = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    out_rdy = 1'b0;
    check("wrap_abort_val", out_val, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
